// File: rtl/btn_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel button detector.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_e;

  // Registered per-channel event pulses, one clk wide each.
  typedef struct packed {
    logic rise;
    logic fall;
    logic long_p;
    logic rep;
  } btn_evt_t;

  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Bits needed to hold 0..max_val; at least one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int hold_width(input int long_ticks, input int repeat_ticks);
    return cnt_width((long_ticks > repeat_ticks) ? long_ticks : repeat_ticks);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, tick-sampled history filter, edge pulses
// and the press/long-press/repeat state machine.
module btn_channel
  import btn_pkg::*;
#(
  parameter int FILTER_DEPTH = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     tick,
  input  logic     btn_raw,
  output logic     btn_state,
  output btn_evt_t evt
);

  localparam int CW = hold_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_TICKS > 0) ? CW'(REPEAT_TICKS - 1) : '0;

  logic [1:0]              sync;
  logic [FILTER_DEPTH-1:0] hist;
  logic [FILTER_DEPTH-1:0] hist_nxt;
  logic                    state_nxt;
  logic                    state_d;

  hold_state_e st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          long_nxt, rep_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], btn_raw};
  end

  assign hist_nxt = {hist[FILTER_DEPTH-2:0], sync[1]};

  // Hysteresis: only a full run of equal samples moves the level.
  always_comb begin
    state_nxt = btn_state;
    if (tick) begin
      if (&hist_nxt)       state_nxt = 1'b1;
      else if (~|hist_nxt) state_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      btn_state <= 1'b0;
      state_d   <= 1'b0;
    end else begin
      if (tick) hist <= hist_nxt;
      btn_state <= state_nxt;
      state_d   <= btn_state;
    end
  end

  // FSM follows the level being written this cycle, so a release landing on a
  // repeat tick suppresses that repeat.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    long_nxt = 1'b0;
    rep_nxt  = 1'b0;
    if (!state_nxt) begin
      st_nxt  = IDLE;
      cnt_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          st_nxt  = PRESSED;
          cnt_nxt = '0;
        end
        PRESSED: if (tick) begin
          if (cnt == LONG_LAST) begin
            long_nxt = 1'b1;
            cnt_nxt  = '0;
            st_nxt   = HELD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: if (tick && (REPEAT_TICKS > 0)) begin
          if (cnt == REP_LAST) begin
            rep_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= '0;
      evt <= '0;
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      evt.rise   <= btn_state & ~state_d;
      evt.fall   <= ~btn_state & state_d;
      evt.long_p <= long_nxt;
      evt.rep    <= rep_nxt;
    end
  end

endmodule

// File: rtl/multi_button_detector.sv
// Debounced multi-button detector: one shared sample tick, NUM_BTN independent
// channels reporting edges, long presses and auto-repeat.
module multi_button_detector
  import btn_pkg::*;
#(
  parameter int NUM_BTN      = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SAMPLE_HZ    = 1_000,
  parameter int FILTER_DEPTH = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] rising_edge,
  output logic [NUM_BTN-1:0] falling_edge,
  output logic [NUM_BTN-1:0] both_edge,
  output logic [NUM_BTN-1:0] long_press,
  // "repeat" is a reserved word, hence the suffix
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int DW  = cnt_width(DIV - 1);

  logic [DW-1:0]  div_cnt;
  logic           tick;
  btn_evt_t [NUM_BTN-1:0] evt;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .FILTER_DEPTH(FILTER_DEPTH),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_raw  (i_btn[g]),
      .btn_state(btn_state[g]),
      .evt      (evt[g])
    );

    assign rising_edge[g]  = evt[g].rise;
    assign falling_edge[g] = evt[g].fall;
    assign both_edge[g]    = evt[g].rise | evt[g].fall;
    assign long_press[g]   = evt[g].long_p;
    assign repeat_pulse[g] = evt[g].rep;
  end

endmodule

// File: tb/tb_multi_button_detector.sv
// Directed bench with an event scoreboard for multi_button_detector.
module tb_multi_button_detector;

  localparam int NB = 4, CLK_HZ = 1000, SAMPLE_HZ = 100, DIV = 10;
  localparam int FD = 4, LT = 20, RT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] i_btn = '0;
  logic [NB-1:0] btn_state, rising_edge, falling_edge, both_edge, long_press, repeat_pulse;

  multi_button_detector #(
    .NUM_BTN(NB), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ),
    .FILTER_DEPTH(FD), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn), .btn_state(btn_state),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .both_edge(both_edge),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int cyc;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct { int ch; int kind; int cyc; } exp_t;
  exp_t sb[$];
  string kname [4] = '{"rise", "fall", "long", "rep"};

  // cyc = clk edges since reset release; events registered on edge N are seen with cyc == N
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    if (cyc > t) check("wait_overrun", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  // First tick edge whose sample sees a level driven just after edge n (two sync flops).
  function automatic int first_tick(input int n);
    return ((n + 3 + DIV - 1) / DIV) * DIV;
  endfunction

  function automatic int level_edge(input int n);
    return first_tick(n) + (FD - 1) * DIV;
  endfunction

  task automatic push(input int ch, input int kind, input int c);
    exp_t e;
    e.ch = ch; e.kind = kind; e.cyc = c;
    sb.push_back(e);
  endtask

  // Expected events for a clean press driven after edge np and released after edge nr.
  task automatic expect_press(input int ch, input int np, input int nr);
    int b, f, r;
    b = level_edge(np);
    f = level_edge(nr);
    push(ch, 0, b + 1);
    push(ch, 1, f + 1);
    if (b + LT * DIV < f) begin
      push(ch, 2, b + LT * DIV);
      r = b + LT * DIV + RT * DIV;
      while (r < f) begin
        push(ch, 3, r);
        r += RT * DIV;
      end
    end
  endtask

  logic [NB-1:0] mon_v [4];

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      mon_v[0] = rising_edge;
      mon_v[1] = falling_edge;
      mon_v[2] = long_press;
      mon_v[3] = repeat_pulse;
      check("both_edge", both_edge, rising_edge | falling_edge);
      for (int c = 0; c < NB; c++) begin
        for (int k = 0; k < 4; k++) begin
          if (mon_v[k][c]) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].ch == c && sb[i].kind == k) idx = i;
            checks++;
            assert (idx >= 0) else begin
              errors++;
              $error("FAIL unexpected_%s ch%0d observed=1 expected=0 (cyc %0d)", kname[k], c, cyc);
            end
            if (idx >= 0) begin
              check($sformatf("%s_ch%0d_cycle", kname[k], c), cyc, sb[idx].cyc);
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_btn = '0;
    repeat (3) @(negedge clk);
    check("rst_state", btn_state, 0);
    check("rst_pulses", {rising_edge, falling_edge, long_press, repeat_pulse}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // clean press on ch0: level on 4th tick, one-cycle rising pulse
    wait_to(5);
    i_btn[0] = 1'b1;
    expect_press(0, 5, 60);
    wait_to(39);  check("ch0_pre_level", btn_state[0], 0);
    wait_to(40);  check("ch0_level", btn_state[0], 1);
    wait_to(42);  check("ch0_rise_width", rising_edge[0], 0);
    wait_to(60);  i_btn[0] = 1'b0;
    wait_to(100); check("ch0_released", btn_state[0], 0);

    // ch1: short pulse of three ticks, then tick-rate bounce, then a real press
    wait_to(110); i_btn[1] = 1'b1;
    wait_to(140); i_btn[1] = 1'b0;
    wait_to(200); check("ch1_glitch", btn_state[1], 0);
    for (int i = 0; i < 8; i++) begin
      i_btn[1] = (i % 2 == 0);
      wait_to(200 + 10 * (i + 1));
    end
    check("ch1_bounce", btn_state[1], 0);
    i_btn[1] = 1'b1;
    expect_press(1, 280, 400);
    wait_to(319); check("ch1_pre_level", btn_state[1], 0);
    wait_to(320); check("ch1_level", btn_state[1], 1);
    wait_to(400); i_btn[1] = 1'b0;

    // ch2 held 300 clk: long press, one repeat, release on a repeat tick
    wait_to(450); i_btn[2] = 1'b1;
    expect_press(2, 450, 750);
    wait_to(690); check("ch2_long", long_press, 4'b0100);
    wait_to(740); check("ch2_repeat", repeat_pulse, 4'b0100);
    wait_to(750); i_btn[2] = 1'b0;
    wait_to(790); check("ch2_rel_repeat", repeat_pulse, 0);
    wait_to(800); check("ch2_released", btn_state, 0);

    // simultaneous ch0 + ch3
    wait_to(810); i_btn = 4'b1001;
    expect_press(0, 810, 900);
    expect_press(3, 810, 900);
    wait_to(851); check("ch03_rise", rising_edge, 4'b1001);
    wait_to(900); i_btn = '0;

    // ch1 into HELD, then reset mid-press
    wait_to(950); i_btn[1] = 1'b1;
    push(1, 0, level_edge(950) + 1);
    push(1, 2, level_edge(950) + LT * DIV);
    wait_to(1200);
    check("ch1_held_level", btn_state[1], 1);
    check("sb_before_reset", sb.size(), 0);
    reset = 1'b1;
    #1;
    check("rst_mid_state", btn_state, 0);
    check("rst_mid_pulses", {rising_edge, falling_edge, long_press, repeat_pulse}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_press(1, 0, 100);
    wait_to(41);  check("ch1_rise_after_rst", rising_edge, 4'b0010);
    wait_to(100); i_btn[1] = 1'b0;
    wait_to(160);
    check("sb_empty", sb.size(), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
